// File: rtl/rgbstr_pkg.sv
// rgbstr_pkg: shared definitions for the 26-bit RGB stream bus.
//   - bit positions of every field in a stream word
//   - default 640x480@60 timing constants
//   - make_word(): packs the fields into a stream word
// Imported by the timing generator and by every overlay stage.
package rgbstr_pkg;

    localparam int RGBSTR_W = 26;

    // Field positions inside a stream word
    localparam int ACTIVE = 0;
    localparam int VS     = 1;
    localparam int HS     = 2;
    localparam int YC_LSB = 3;
    localparam int YC_MSB = 12;
    localparam int XC_LSB = 13;
    localparam int XC_MSB = 22;
    localparam int R      = 23;
    localparam int G      = 24;
    localparam int B      = 25;

    // Default 640x480@60 timing
    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    typedef logic [RGBSTR_W-1:0] rgbstr_word_t;

    // rgb is {B,G,R}, landing on bits [25:23]
    function automatic rgbstr_word_t make_word(input logic [2:0] rgb,
                                               input logic [9:0] xc,
                                               input logic [9:0] yc,
                                               input logic       hs,
                                               input logic       vs,
                                               input logic       active);
        return {rgb, xc, yc, hs, vs, active};
    endfunction

endpackage

// File: rtl/rgbstr_timing_gen_if.sv
// rgbstr_timing_gen_if: bundle between the timing generator and its consumer.
//   en          pixel enable (into the generator)
//   bg_color    background colour {B,G,R} (into the generator)
//   RGBStr_o    26-bit stream word (out of the generator)
//   line_start  pulse on the word with XC=0
//   frame_start pulse on the word with XC=0, YC=0
// master = timing generator side, slave = driver/consumer side.
interface rgbstr_timing_gen_if;
    import rgbstr_pkg::*;

    logic               en;
    logic [2:0]         bg_color;
    logic [RGBSTR_W-1:0] RGBStr_o;
    logic               line_start;
    logic               frame_start;

    modport master (
        input  en,
        input  bg_color,
        output RGBStr_o,
        output line_start,
        output frame_start
    );

    modport slave (
        output en,
        output bg_color,
        input  RGBStr_o,
        input  line_start,
        input  frame_start
    );

endinterface

// File: rtl/rgbstr_timing_gen_wrap_counter.sv
// wrap_counter: counter that counts 0..MAX, advancing when inc is high.
//   px_clk  clock
//   rst_n   asynchronous active-low reset (count -> 0)
//   inc     advance request
//   count   current value
//   wrap    high in the cycle where inc is high and count == MAX
//           (combinational; the next count is 0)
module wrap_counter #(
    parameter int WIDTH = 10,
    parameter int MAX   = 799
) (
    input  logic             px_clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    assign wrap = inc && (count == MAX_V);

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/rgbstr_timing_gen.sv
// rgbstr_timing_gen: source of the RGB stream bus.
// Free-running horizontal/vertical counters; on every enabled px_clk edge a
// stream word is registered from the pre-increment counter values, so the
// output trails the counters by one cycle and all fields stay consistent.
//   px_clk  pixel clock
//   rst_n   asynchronous active-low reset
//   bus     master modport: en, bg_color in; RGBStr_o, line_start,
//           frame_start out
module rgbstr_timing_gen
    import rgbstr_pkg::*;
#(
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic                 px_clk,
    input  logic                 rst_n,
    rgbstr_timing_gen_if.master  bus
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_timing
        $error("rgbstr_timing_gen: H_TOT/V_TOT must not exceed 1024");
    end

    // Bounds held in 11 bits: a sync end can equal 1024 when the back
    // porch is zero and the total is exactly 1024.
    localparam logic [10:0] H_VIS_C   = 11'(H_VIS);
    localparam logic [10:0] H_HS_BEG  = 11'(H_VIS + H_FP);
    localparam logic [10:0] H_HS_END  = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_C   = 11'(V_VIS);
    localparam logic [10:0] V_VS_BEG  = 11'(V_VIS + V_FP);
    localparam logic [10:0] V_VS_END  = 11'(V_VIS + V_FP + V_SYNC);

    localparam rgbstr_word_t RESET_WORD =
        {3'b000, 10'd0, 10'd0, ~HS_POL, ~VS_POL, 1'b0};

    logic [9:0]   hc;
    logic [9:0]   vc;
    logic         h_wrap;
    logic         v_wrap;
    logic         active_next;
    logic         hs_next;
    logic         vs_next;
    rgbstr_word_t word_next;
    rgbstr_word_t word_reg;
    logic         line_start_reg;
    logic         frame_start_reg;

    wrap_counter #(.WIDTH(10), .MAX(H_TOT - 1)) u_hcnt (
        .px_clk (px_clk),
        .rst_n  (rst_n),
        .inc    (bus.en),
        .count  (hc),
        .wrap   (h_wrap)
    );

    // Vertical advances only on the horizontal wrap, which already
    // includes the enable.
    wrap_counter #(.WIDTH(10), .MAX(V_TOT - 1)) u_vcnt (
        .px_clk (px_clk),
        .rst_n  (rst_n),
        .inc    (h_wrap),
        .count  (vc),
        .wrap   (v_wrap)
    );

    always_comb begin
        active_next = ({1'b0, hc} < H_VIS_C) && ({1'b0, vc} < V_VIS_C);
        hs_next     = (({1'b0, hc} >= H_HS_BEG) && ({1'b0, hc} < H_HS_END))
                      ? HS_POL : ~HS_POL;
        vs_next     = (({1'b0, vc} >= V_VS_BEG) && ({1'b0, vc} < V_VS_END))
                      ? VS_POL : ~VS_POL;
        word_next   = make_word(active_next ? bus.bg_color : 3'b000,
                                hc, vc, hs_next, vs_next, active_next);
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg        <= RESET_WORD;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else if (bus.en) begin
            word_reg        <= word_next;
            line_start_reg  <= (hc == 10'd0);
            frame_start_reg <= (hc == 10'd0) && (vc == 10'd0);
        end else begin
            // Stalled: word holds, but pulses must not repeat.
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end
    end

    assign bus.RGBStr_o    = word_reg;
    assign bus.line_start  = line_start_reg;
    assign bus.frame_start = frame_start_reg;

endmodule

// File: tb/tb_rgbstr_timing_gen.sv
// Directed bench for rgbstr_timing_gen: a default 640x480 instance for
// line/hold/reset behaviour and a tiny-timing instance for whole-frame checks.
module tb_rgbstr_timing_gen;
    import rgbstr_pkg::*;

    logic px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    logic rst_n;
    logic rst2_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    rgbstr_timing_gen_if bus ();
    rgbstr_timing_gen_if bus2 ();

    rgbstr_timing_gen dut (
        .px_clk (px_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // Tiny timing: H 4+1+2+1 = 8, V 3+1+2+1 = 7, frame = 56 cycles.
    // HS active-high (XC 5..6), VS active-low (YC 4..5).
    rgbstr_timing_gen #(
        .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut2 (
        .px_clk (px_clk),
        .rst_n  (rst2_n),
        .bus    (bus2)
    );

    task automatic chk(input string tag, input logic [25:0] obs, input logic [25:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge px_clk);
        #1;
    endtask

    function automatic logic [9:0] xc_of(input logic [25:0] w);
        return w[XC_MSB:XC_LSB];
    endfunction
    function automatic logic [9:0] yc_of(input logic [25:0] w);
        return w[YC_MSB:YC_LSB];
    endfunction
    function automatic logic [2:0] rgb_of(input logic [25:0] w);
        return w[B:R];
    endfunction

    initial begin
        int seq_err, act_err, rgb_err, hs_cnt, hs_first, hs_last;
        int vs_low, vs_bad, fs_bad, hs_hi, act_cnt, hold_err, wraps;
        logic [9:0]  prev_x, exp_x;
        logic [25:0] held, prev_w;

        rst_n = 1'b0; rst2_n = 1'b0;
        bus.en = 1'b0;  bus.bg_color = 3'b101;
        bus2.en = 1'b0; bus2.bg_color = 3'b111;
        repeat (3) step();

        // ---------------- tiny instance: whole frame ----------------
        chk("small_reset_word", bus2.RGBStr_o, 26'h0000002);
        rst2_n = 1'b1;
        bus2.en = 1'b1;
        step();
        chk("small_first_word", bus2.RGBStr_o, 26'h3800007 & ~26'h4); // RGB 111, HS=0, VS=1, Act=1
        chk("small_first_fs", bus2.frame_start, 1'b1);
        vs_low = 0; vs_bad = 0; fs_bad = 0; hs_hi = 0; act_cnt = 0; rgb_err = 0;
        for (int k = 0; k < 56; k++) begin
            if (k != 0) begin
                step();
                if (bus2.frame_start) fs_bad++;
            end
            if (!bus2.RGBStr_o[VS]) begin
                vs_low++;
                if (yc_of(bus2.RGBStr_o) != 10'd4 && yc_of(bus2.RGBStr_o) != 10'd5) vs_bad++;
            end
            if (bus2.RGBStr_o[HS]) hs_hi++;
            if (bus2.RGBStr_o[ACTIVE]) begin
                act_cnt++;
                if (yc_of(bus2.RGBStr_o) >= 10'd3 || rgb_of(bus2.RGBStr_o) != 3'b111) rgb_err++;
            end else if (rgb_of(bus2.RGBStr_o) != 3'b000) rgb_err++;
        end
        step();
        chk("small_fs_recur", bus2.frame_start, 1'b1);
        chk("small_fs_xy", {xc_of(bus2.RGBStr_o), yc_of(bus2.RGBStr_o)}, 20'd0);
        chk("small_fs_spurious", fs_bad, 0);
        chk("small_vs_low_cnt", vs_low, 16);
        chk("small_vs_low_rows", vs_bad, 0);
        chk("small_hs_hi_cnt", hs_hi, 14);
        chk("small_active_cnt", act_cnt, 12);
        chk("small_rgb_blank", rgb_err, 0);
        bus2.en = 1'b0;

        // ---------------- default instance ----------------
        chk("reset_word", bus.RGBStr_o, 26'h0000006);
        chk("reset_ls", bus.line_start, 1'b0);
        chk("reset_fs", bus.frame_start, 1'b0);
        rst_n = 1'b1;
        step();
        chk("idle_after_release", bus.RGBStr_o, 26'h0000006);
        bus.en = 1'b1;
        step();
        chk("first_word", bus.RGBStr_o, 26'h2800007);
        chk("first_ls", bus.line_start, 1'b1);
        chk("first_fs", bus.frame_start, 1'b1);
        step();
        chk("second_word", bus.RGBStr_o, 26'h2802007);
        chk("second_ls", bus.line_start, 1'b0);
        chk("second_fs", bus.frame_start, 1'b0);

        seq_err = 0; act_err = 0; rgb_err = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int i = 2; i < 800; i++) begin
            step();
            if (xc_of(bus.RGBStr_o) != 10'(i)) seq_err++;
            if (bus.RGBStr_o[ACTIVE] !== (i < 640)) act_err++;
            if (rgb_of(bus.RGBStr_o) != ((i < 640) ? 3'b101 : 3'b000)) rgb_err++;
            if (!bus.RGBStr_o[HS]) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
        end
        chk("line_xc_seq", seq_err, 0);
        chk("line_active_edge", act_err, 0);
        chk("line_rgb", rgb_err, 0);
        chk("line_hs_width", hs_cnt, 96);
        chk("line_hs_first", hs_first, 656);
        chk("line_hs_last", hs_last, 751);
        step();
        chk("wrap_xc", xc_of(bus.RGBStr_o), 10'd0);
        chk("wrap_yc", yc_of(bus.RGBStr_o), 10'd1);
        chk("wrap_ls", bus.line_start, 1'b1);
        chk("wrap_fs", bus.frame_start, 1'b0);

        // Hold at XC=100
        repeat (100) step();
        chk("pre_hold_xc", xc_of(bus.RGBStr_o), 10'd100);
        held = bus.RGBStr_o;
        bus.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_word", bus.RGBStr_o, held);
            chk("hold_ls", bus.line_start, 1'b0);
            chk("hold_fs", bus.frame_start, 1'b0);
        end
        bus.bg_color = 3'b011;
        bus.en = 1'b1;
        step();
        chk("resume_xc", xc_of(bus.RGBStr_o), 10'd101);
        chk("resume_yc", yc_of(bus.RGBStr_o), 10'd1);
        chk("resume_bg_sampled", rgb_of(bus.RGBStr_o), 3'b011);

        // Toggle en every other cycle for one full line of enabled words
        bus.bg_color = 3'b101;
        prev_x = 10'd101; seq_err = 0; hold_err = 0; hs_cnt = 0; wraps = 0;
        for (int k = 0; k < 1600; k++) begin
            bus.en = (k % 2 == 0);
            prev_w = bus.RGBStr_o;
            step();
            if (k % 2 == 0) begin
                exp_x = (prev_x == 10'd799) ? 10'd0 : prev_x + 10'd1;
                if (xc_of(bus.RGBStr_o) != exp_x) seq_err++;
                if (xc_of(bus.RGBStr_o) == 10'd0) begin
                    wraps++;
                    if (!bus.line_start) seq_err++;
                end
                if (!bus.RGBStr_o[HS]) hs_cnt++;
                prev_x = xc_of(bus.RGBStr_o);
            end else if (bus.RGBStr_o != prev_w || bus.line_start || bus.frame_start) begin
                hold_err++;
            end
        end
        bus.en = 1'b1;
        chk("toggle_seq", seq_err, 0);
        chk("toggle_hold", hold_err, 0);
        chk("toggle_hs_width", hs_cnt, 96);
        chk("toggle_wraps", wraps, 1);
        chk("toggle_end_xc", xc_of(bus.RGBStr_o), 10'd101);
        chk("toggle_end_yc", yc_of(bus.RGBStr_o), 10'd2);

        // Asynchronous reset mid-line
        repeat (199) step();
        chk("pre_reset_xc", xc_of(bus.RGBStr_o), 10'd300);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_word", bus.RGBStr_o, 26'h0000006);
        chk("async_reset_ls", bus.line_start, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("restart_word", bus.RGBStr_o, 26'h2800007);
        chk("restart_fs", bus.frame_start, 1'b1);
        step();
        chk("restart_next_xc", xc_of(bus.RGBStr_o), 10'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
